// File: rtl/rpc_seq_adder.sv
// rtl/rpc_seq_adder.sv - multi-cycle wide add/sub built on one narrow rpc_adder
//
// Purpose: adds or subtracts two W-bit operands one NR_BITS-wide chunk per clock,
//          LSB chunk first, chaining the carry between chunks through a register.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start           request; sampled only while ready=1
//   sub             0: a+b+c_in, 1: a-b (c_in ignored)
//   c_in            carry-in for addition
//   a, b            W-bit operands, latched on the accepting edge
//   ready/busy/done one-hot status for IDLE/RUN/DONE; done is a one-cycle pulse
//   sum             W-bit result register
//   c_out           final carry (for sub: 1 = no borrow)
//   overflow        two's-complement signed overflow of the full-width result

module rpc_adder #(
  parameter int NR_BITS = 4
) (
  input  logic [NR_BITS-1:0] i_a,
  input  logic [NR_BITS-1:0] i_b,
  input  logic               i_c,
  output logic [NR_BITS-1:0] o_sum,
  output logic               o_c
);
  assign {o_c, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{NR_BITS{1'b0}}, i_c};
endmodule

module rpc_seq_adder #(
  parameter int NR_BITS   = 4,
  parameter int NR_CHUNKS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         sub,
  input  logic                         c_in,
  input  logic [NR_BITS*NR_CHUNKS-1:0] a,
  input  logic [NR_BITS*NR_CHUNKS-1:0] b,
  output logic                         ready,
  output logic                         busy,
  output logic                         done,
  output logic [NR_BITS*NR_CHUNKS-1:0] sum,
  output logic                         c_out,
  output logic                         overflow
);
  localparam int W     = NR_BITS * NR_CHUNKS;
  localparam int IDX_W = (NR_CHUNKS > 1) ? $clog2(NR_CHUNKS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;   // effective B: already inverted for subtraction
  logic [W-1:0]       r_sum;
  logic               r_c_out;
  logic               r_ovf;

  logic [NR_BITS-1:0] w_a_chunk;
  logic [NR_BITS-1:0] w_b_chunk;
  logic [NR_BITS-1:0] w_s_chunk;
  logic               w_ac;
  logic               w_last;

  assign w_last = (r_idx == IDX_W'(NR_CHUNKS - 1));

  // Chunk select written as a constant-index mux so that no variable part-select
  // width arithmetic is needed.
  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < NR_CHUNKS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_chunk = r_a[k*NR_BITS +: NR_BITS];
        w_b_chunk = r_b[k*NR_BITS +: NR_BITS];
      end
    end
  end

  rpc_adder #(.NR_BITS(NR_BITS)) u_adder (
    .i_a   (w_a_chunk),
    .i_b   (w_b_chunk),
    .i_c   (r_carry),
    .o_sum (w_s_chunk),
    .o_c   (w_ac)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            // a - b computed as a + ~b + 1
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NR_CHUNKS; k++) begin
            if (r_idx == IDX_W'(k)) r_sum[k*NR_BITS +: NR_BITS] <= w_s_chunk;
          end
          r_carry <= w_ac;
          if (w_last) begin
            r_c_out <= w_ac;
            r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_s_chunk[NR_BITS-1] != r_a[W-1]);
            r_idx   <= '0;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign c_out    = r_c_out;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_rpc_seq_adder.sv
// tb/tb_rpc_seq_adder.sv - directed self-checking bench for rpc_seq_adder

module tb_rpc_seq_adder;
  logic        clk;
  logic        rst;
  logic        start, sub, c_in;
  logic [15:0] a, b;
  logic        ready, busy, done, c_out, overflow;
  logic [15:0] sum;

  logic        start2, sub2, c_in2;
  logic [15:0] a2, b2;
  logic        ready2, busy2, done2, c_out2, overflow2;
  logic [15:0] sum2;

  int n_tests = 0;
  int n_fail  = 0;

  rpc_seq_adder #(.NR_BITS(4), .NR_CHUNKS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .c_in(c_in),
    .a(a), .b(b), .ready(ready), .busy(busy), .done(done),
    .sum(sum), .c_out(c_out), .overflow(overflow)
  );

  rpc_seq_adder #(.NR_BITS(8), .NR_CHUNKS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .c_in(c_in2),
    .a(a2), .b(b2), .ready(ready2), .busy(busy2), .done(done2),
    .sum(sum2), .c_out(c_out2), .overflow(overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation on the 4x4 instance; checks latency, busy width and result.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vsub, input logic vcin,
                        input logic [15:0] esum, input logic ec, input logic eov);
    int e;
    int nb;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    a = va; b = vb; sub = vsub; c_in = vcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; sub = ~vsub; c_in = ~vcin;
    e = 0; nb = 0;
    while (!done && e < 20) begin
      if (busy) nb++;
      @(negedge clk);
      e++;
    end
    check({tag, "_latency"}, e, 4);
    check({tag, "_busy"}, nb, 4);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
    check({tag, "_cout"}, {31'd0, c_out}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eov});
    @(negedge clk);
    check({tag, "_done1"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {16'd0, sum}, {16'd0, esum});
  endtask

  initial begin
    int d_at[$];
    logic [15:0] d_sum[$];
    int e;

    rst = 1'b1;
    start = 0; sub = 0; c_in = 0; a = 0; b = 0;
    start2 = 0; sub2 = 0; c_in2 = 0; a2 = 0; b2 = 0;
    #12;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, c_out}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub2", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    run_op("cin",  16'h0010, 16'h0020, 1'b0, 1'b1, 16'h0031, 1'b0, 1'b0);

    // start held for 12 edges: two operations, each with its own latched operands
    @(negedge clk);
    a = 16'h0001; b = 16'h0002; sub = 0; c_in = 0; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) begin
        d_at.push_back(k);
        d_sum.push_back(sum);
      end
      if (k == 1) begin a = 16'h1000; b = 16'h2000; end
      if (k == 7) begin a = 16'hFFFF; b = 16'hFFFF; end
      if (k == 11) start = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) begin
        d_at.push_back(12 + k);
        d_sum.push_back(sum);
      end
    end
    check("held_count", d_at.size(), 2);
    if (d_at.size() == 2) begin
      check("held_first_at", d_at[0], 4);
      check("held_gap", d_at[1] - d_at[0], 6);
      check("held_sum0", {16'd0, d_sum[0]}, 32'h0003);
      check("held_sum1", {16'd0, d_sum[1]}, 32'h3000);
    end

    // asynchronous reset after two chunks of a RUN
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_partial", {24'd0, sum[7:0]}, 32'h55);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", {31'd0, ready}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_sum", {16'd0, sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    // 8-bit x 2-chunk configuration
    @(negedge clk);
    a2 = 16'hABCD; b2 = 16'h1234; c_in2 = 1'b1; sub2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; a2 = 16'h0;
    e = 0;
    while (!done2 && e < 20) begin
      @(negedge clk);
      e++;
    end
    check("w8_latency", e, 2);
    check("w8_sum", {16'd0, sum2}, 32'hBE02);
    check("w8_cout", {31'd0, c_out2}, 32'd0);
    check("w8_ovf", {31'd0, overflow2}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
